// File: rtl/wb_sram_responder.sv
// Wishbone classic slave backed by a word-addressed SRAM.
// Every transfer is captured in IDLE, waits WAIT_STATES-1 cycles in WAIT,
// and is answered in a single RESP cycle with ack (in range) or err (out of range).
module wb_sram_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [29:0] BASE_ADR    = 30'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus__cyc,
  input  logic        bus__stb,
  input  logic        bus__we,
  input  logic [3:0]  bus__sel,
  input  logic [29:0] bus__adr,
  input  logic [31:0] bus__dat_w,
  output logic [31:0] bus__dat_r,
  output logic        bus__ack,
  output logic        bus__err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_LOAD = 2'(WAIT_STATES - 1);

  if (WAIT_STATES < 1 || WAIT_STATES > 3) begin : g_bad_wait_states
    $error("wb_sram_responder: WAIT_STATES must be 1..3");
  end

  if (DEPTH_WORDS < 4 || DEPTH_WORDS > 4096 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("wb_sram_responder: DEPTH_WORDS must be a power of two in 4..4096");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic [29:0] adr_q,   adr_d;
  logic        we_q,    we_d;
  logic [3:0]  sel_q,   sel_d;
  logic [31:0] dat_q,   dat_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          resp;
  logic          mem_we;

  // Offset arithmetic wraps mod 2^30, so addresses below BASE_ADR land far out of range.
  assign off      = adr_q - BASE_ADR;
  assign idx      = off[AW-1:0];
  assign in_range = (off[29:AW] == '0);
  assign resp     = (state_q == S_RESP);
  // The write commits in RESP even if cyc drops there: the master has already seen ack.
  assign mem_we   = resp && in_range && we_q;

  assign bus__ack   = resp && in_range && bus__cyc;
  assign bus__err   = resp && !in_range;
  assign bus__dat_r = (resp && in_range && !we_q) ? mem[idx] : 32'h0;

  // State, wait counter and captured request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
    end
  end

  // Next-state logic: capture in IDLE, count down in WAIT, single-cycle RESP.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus__cyc && bus__stb) begin
          adr_d   = bus__adr;
          we_d    = bus__we;
          sel_d   = bus__sel;
          dat_d   = bus__dat_w;
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_STATES == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus__cyc) begin
          // Master abandoned the cycle: drop the transfer silently.
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte-lane write port, committed on the edge that ends the RESP cycle.
  always_ff @(posedge clk) begin
    // NOTE: memory is intentionally not reset; contents are undefined until written.
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Bench for wb_sram_responder: three instances with different wait states,
// base addresses and depths share one bus; a transaction-level model predicts
// every output on every cycle, and directed scenarios pin hand-computed values.
module tb_wb_sram_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_cyc, bus_stb, bus_we;
  logic [3:0]  bus_sel;
  logic [29:0] bus_adr;
  logic [31:0] bus_dat_w;

  wire [N-1:0] ack_v, err_v;
  wire [31:0]  dat_v [N];

  int total = 0;
  int bad   = 0;

  // Instance parameters as seen by the model.
  int          ws_p    [N] = '{1, 3, 2};
  int          depth_p [N] = '{256, 256, 16};
  logic [29:0] base_p  [N] = '{30'h0, 30'h100, 30'h0};

  wb_sram_responder #(.DEPTH_WORDS(256), .BASE_ADR(30'h0),   .WAIT_STATES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus__cyc(bus_cyc), .bus__stb(bus_stb), .bus__we(bus_we),
    .bus__sel(bus_sel), .bus__adr(bus_adr), .bus__dat_w(bus_dat_w),
    .bus__dat_r(dat_v[0]), .bus__ack(ack_v[0]), .bus__err(err_v[0]));

  wb_sram_responder #(.DEPTH_WORDS(256), .BASE_ADR(30'h100), .WAIT_STATES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus__cyc(bus_cyc), .bus__stb(bus_stb), .bus__we(bus_we),
    .bus__sel(bus_sel), .bus__adr(bus_adr), .bus__dat_w(bus_dat_w),
    .bus__dat_r(dat_v[1]), .bus__ack(ack_v[1]), .bus__err(err_v[1]));

  wb_sram_responder #(.DEPTH_WORDS(16),  .BASE_ADR(30'h0),   .WAIT_STATES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .bus__cyc(bus_cyc), .bus__stb(bus_stb), .bus__we(bus_we),
    .bus__sel(bus_sel), .bus__adr(bus_adr), .bus__dat_w(bus_dat_w),
    .bus__dat_r(dat_v[2]), .bus__ack(ack_v[2]), .bus__err(err_v[2]));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          cur = 0;              // index of the cycle currently in progress
  bit          busy    [N];
  int          resp_at [N];          // cycle in which the response must appear
  logic        we_m    [N];
  logic [3:0]  sel_m   [N];
  logic [29:0] adr_m   [N];
  logic [31:0] dat_m   [N];
  logic [31:0] mmem    [N][256];
  logic [3:0]  mwr     [N][256];     // per-byte "has been written" flags
  int          cap_cnt [N];
  int          rsp_cnt [N];
  int          last_rsp[N];

  function automatic logic [29:0] off_of(input int i, input logic [29:0] a);
    return a - base_p[i];
  endfunction

  function automatic bit in_rng(input int i, input logic [29:0] a);
    return off_of(i, a) < 30'(depth_p[i]);
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      busy[i] = 0; resp_at[i] = 0; cap_cnt[i] = 0; rsp_cnt[i] = 0; last_rsp[i] = -1;
      we_m[i] = 0; sel_m[i] = 0; adr_m[i] = 0; dat_m[i] = 0;
      for (int w = 0; w < 256; w++) begin
        mmem[i][w] = 32'h0;
        mwr[i][w]  = 4'h0;
      end
    end
  end

  // Model update at each rising edge, using the inputs of the cycle that just ended.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        int o;
        if (busy[i] && cur == resp_at[i]) begin
          if (we_m[i] && in_rng(i, adr_m[i])) begin
            o = int'(off_of(i, adr_m[i]));
            for (int b = 0; b < 4; b++) begin
              if (sel_m[i][b]) begin
                mmem[i][o][8*b +: 8] = dat_m[i][8*b +: 8];
                mwr[i][o][b] = 1'b1;
              end
            end
          end
          busy[i] = 0;
        end else if (busy[i]) begin
          if (!bus_cyc) busy[i] = 0;
        end else if (bus_cyc && bus_stb) begin
          busy[i]    = 1;
          resp_at[i] = cur + ws_p[i];
          we_m[i]    = bus_we;
          sel_m[i]   = bus_sel;
          adr_m[i]   = bus_adr;
          dat_m[i]   = bus_dat_w;
          cap_cnt[i]++;
        end
      end
    end
    cur++;
  end

  // Reset discards any in-flight transfer immediately.
  always @(negedge rst_n) begin
    for (int i = 0; i < N; i++) busy[i] = 0;
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      bit          rnow, rng, known;
      logic        e_ack, e_err;
      logic [31:0] e_dat;
      int          o;
      rnow  = busy[i] && (resp_at[i] == cur);
      rng   = in_rng(i, adr_m[i]);
      e_ack = rnow && rng && bus_cyc;
      e_err = rnow && !rng;
      e_dat = 32'h0;
      known = 1;
      if (rnow && rng && !we_m[i]) begin
        o     = int'(off_of(i, adr_m[i]));
        e_dat = mmem[i][o];
        known = (mwr[i][o] == 4'hF);
      end
      check($sformatf("ack[%0d]@%0d", i, cur), ack_v[i], e_ack);
      check($sformatf("err[%0d]@%0d", i, cur), err_v[i], e_err);
      if (known) check($sformatf("dat_r[%0d]@%0d", i, cur), dat_v[i], e_dat);
      if (ack_v[i] || err_v[i]) begin
        if (last_rsp[i] >= 0)
          check($sformatf("resp_gap_ok[%0d]@%0d gap=%0d", i, cur, cur - last_rsp[i]),
                32'(cur - last_rsp[i] >= ws_p[i] + 1), 32'd1);
        last_rsp[i] = cur;
        rsp_cnt[i]++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic        rec_ack [N][8];
  logic        rec_err [N][8];
  logic [31:0] rec_dat [N][8];
  logic        h_ack [8];
  logic        h_err [8];

  logic [3:0]  sel_tab [4] = '{4'b0000, 4'b0011, 4'b1010, 4'b1001};
  logic [31:0] lane_exp[4] = '{32'h0000_0000, 32'h0000_C3D4, 32'hA100_C300, 32'hA100_00D4};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus_cyc = 0; bus_stb = 0; bus_we = 0; bus_sel = 4'h0; bus_adr = '0; bus_dat_w = '0;
    repeat (n) tick();
  endtask

  // Hold one request on the bus for n cycles, recording outputs of each cycle.
  task automatic xfer(input logic we, input logic [3:0] sel, input logic [29:0] adr,
                      input logic [31:0] dat, input int n);
    bus_cyc = 1; bus_stb = 1; bus_we = we; bus_sel = sel; bus_adr = adr; bus_dat_w = dat;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        rec_ack[i][k] = ack_v[i];
        rec_err[i][k] = err_v[i];
        rec_dat[i][k] = dat_v[i];
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    bus_cyc = 0; bus_stb = 0; bus_we = 0; bus_sel = 4'h0; bus_adr = '0; bus_dat_w = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_ack[%0d]", i), ack_v[i], 1'b0);
      check($sformatf("reset_err[%0d]", i), err_v[i], 1'b0);
      check($sformatf("reset_dat[%0d]", i), dat_v[i], 32'h0);
    end
    tick();
    rst_n = 1;
    idle(2);

    // Single-wait-state write then read back (instance a).
    xfer(1'b1, 4'hF, 30'h5, 32'hDEAD_BEEF, 2);
    check("a_wr_ack_cycle0", rec_ack[0][0], 1'b0);
    check("a_wr_ack_cycle1", rec_ack[0][1], 1'b1);
    xfer(1'b0, 4'hF, 30'h5, 32'h0, 2);
    check("a_rd_ack_cycle2", rec_ack[0][0], 1'b0);
    check("a_rd_ack_cycle3", rec_ack[0][1], 1'b1);
    check("a_rd_dat_cycle3", rec_dat[0][1], 32'hDEAD_BEEF);
    idle(4);

    // Byte-lane merge (instance a).
    xfer(1'b1, 4'hF,    30'h2, 32'h1122_3344, 2);
    xfer(1'b1, 4'b0100, 30'h2, 32'hAABB_CCDD, 2);
    xfer(1'b0, 4'hF,    30'h2, 32'h0, 2);
    check("a_lane_merge", rec_dat[0][1], 32'h11BB_3344);
    idle(4);

    // Abort in WAIT, then a fresh read (instance b, three wait states).
    for (int k = 0; k < 8; k++) begin
      bus_we = 0; bus_sel = 4'hF; bus_dat_w = '0;
      if (k < 2)      begin bus_cyc = 1; bus_stb = 1; bus_adr = 30'h100; end
      else if (k < 4) begin bus_cyc = 0; bus_stb = 0; end
      else            begin bus_cyc = 1; bus_stb = 1; bus_adr = 30'h101; end
      @(negedge clk);
      h_ack[k] = ack_v[1];
      h_err[k] = err_v[1];
      tick();
    end
    for (int k = 0; k < 7; k++) check($sformatf("b_abort_noresp_c%0d", k), h_ack[k] | h_err[k], 1'b0);
    check("b_abort_new_ack_c7", h_ack[7], 1'b1);
    idle(4);

    // Range checks (instance b, BASE 0x100, 256 words).
    xfer(1'b1, 4'hF, 30'h100, 32'h1234_5678, 4);
    check("b_preload_ack", rec_ack[1][3], 1'b1);
    xfer(1'b0, 4'hF, 30'h0FF, 32'h0, 4);
    check("b_low_err", rec_err[1][3], 1'b1);
    check("b_low_ack", rec_ack[1][3], 1'b0);
    check("b_low_dat", rec_dat[1][3], 32'h0);
    xfer(1'b0, 4'hF, 30'h200, 32'h0, 4);
    check("b_high_err", rec_err[1][3], 1'b1);
    check("b_high_ack", rec_ack[1][3], 1'b0);
    check("b_high_dat", rec_dat[1][3], 32'h0);
    xfer(1'b1, 4'hF, 30'h200, 32'hFFFF_FFFF, 4);
    check("b_high_wr_err", rec_err[1][3], 1'b1);
    idle(4);
    xfer(1'b0, 4'hF, 30'h100, 32'h0, 4);
    check("b_unchanged_ack", rec_ack[1][3], 1'b1);
    check("b_unchanged_dat", rec_dat[1][3], 32'h1234_5678);
    idle(4);

    // Byte-lane patterns including sel=0 (instance c, two wait states).
    for (int k = 0; k < 4; k++) begin
      xfer(1'b1, 4'hF, 30'(8 + k), 32'h0, 3);
      xfer(1'b1, sel_tab[k], 30'(8 + k), 32'hA1B2_C3D4, 3);
      check($sformatf("c_lane_wr_ack%0d", k), rec_ack[2][2], 1'b1);
      xfer(1'b0, 4'hF, 30'(8 + k), 32'h0, 3);
      check($sformatf("c_lane_rd%0d", k), rec_dat[2][2], lane_exp[k]);
      idle(2);
    end

    // Reset in the middle of a write (instance c in WAIT, instance a in RESP).
    xfer(1'b1, 4'hF, 30'h7, 32'h0, 3);
    idle(3);
    bus_cyc = 1; bus_stb = 1; bus_we = 1; bus_sel = 4'hF; bus_adr = 30'h7; bus_dat_w = 32'hCAFE_F00D;
    tick();
    rst_n = 0;
    bus_cyc = 0; bus_stb = 0; bus_we = 0;
    #1;
    check("rst_async_ack_a", ack_v[0], 1'b0);
    check("rst_async_ack_c", ack_v[2], 1'b0);
    check("rst_async_err_b", err_v[1], 1'b0);
    tick();
    rst_n = 1;
    idle(2);
    xfer(1'b0, 4'hF, 30'h7, 32'h0, 3);
    check("c_after_rst_ack", rec_ack[2][2], 1'b1);
    check("c_after_rst_dat", rec_dat[2][2], 32'h0);
    idle(5);

    // Continuous request for 64 cycles, then stb low with cyc held to drain.
    for (int i = 0; i < N; i++) begin cap_cnt[i] = 0; rsp_cnt[i] = 0; end
    bus_cyc = 1; bus_stb = 1; bus_we = 0; bus_sel = 4'hF; bus_adr = 30'h3; bus_dat_w = '0;
    repeat (64) tick();
    bus_stb = 0;
    repeat (4) tick();
    idle(2);
    for (int i = 0; i < N; i++)
      check($sformatf("stream_resp_eq_cap[%0d]", i), rsp_cnt[i], cap_cnt[i]);
    check("stream_count_a", rsp_cnt[0], 32);
    check("stream_count_b", rsp_cnt[1], 16);
    check("stream_count_c", rsp_cnt[2], 22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sram_responder.md
WB_SRAM_RESPONDER -- requirements
Module: wb_sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words; legal values are powers of two from 4 to 4096.
REQ-002 SHALL have parameter BASE_ADR, default 30'h0, meaning the word address of memory word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 1, meaning the cycles from request capture to ack; legal values are 1 to 3, and 0 SHALL be rejected at elaboration.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port bus__cyc, input, 1 bit: Wishbone cycle.
REQ-007 SHALL have port bus__stb, input, 1 bit: Wishbone strobe.
REQ-008 SHALL have port bus__we, input, 1 bit: write enable.
REQ-009 SHALL have port bus__sel, input, 4 bits: byte lane select, where bit i maps to dat[8i+7:8i].
REQ-010 SHALL have port bus__adr, input, 30 bits: word address.
REQ-011 SHALL have port bus__dat_w, input, 32 bits: write data.
REQ-012 SHALL have port bus__dat_r, output, 32 bits: read data.
REQ-013 SHALL have port bus__ack, output, 1 bit: transfer acknowledge.
REQ-014 SHALL have port bus__err, output, 1 bit: transfer error for an out-of-range address.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 IDLE with bus__cyc&bus__stb high at a rising edge SHALL capture adr, we, sel and dat_w, and load the wait counter with WAIT_STATES-1.
REQ-017 On that same edge the FSM SHALL go to WAIT, or go directly to RESP when WAIT_STATES=1.
REQ-018 WAIT SHALL decrement the counter each edge and go to RESP when the counter reaches 0.
REQ-019 RESP SHALL last exactly one cycle, drive ack or err high for that cycle, and then return to IDLE unconditionally.
REQ-020 Latency: with the request first visible in cycle N, ack/err SHALL be high only in cycle N+WAIT_STATES.
REQ-021 ack/err SHALL never be high in the cycle a request first appears.
REQ-022 ack SHALL never be high when cyc is low.
REQ-023 Back-to-back transfers: a request still held in the RESP cycle SHALL NOT be captured in that cycle; it SHALL be captured in the following IDLE cycle.
REQ-024 The minimum spacing between acks SHALL therefore be WAIT_STATES+1 cycles.
REQ-025 Range check: off = adr - BASE_ADR, mod 2^30, and the request SHALL be in range when off < DEPTH_WORDS.
REQ-026 An out-of-range request SHALL raise err (not ack) in RESP, perform no write, and return dat_r = 0.
REQ-027 A write SHALL update only the bytes whose sel bit is set, at the RESP-cycle rising edge.
REQ-028 sel = 4'b0000 SHALL be acked with no memory change.
REQ-029 Read: dat_r SHALL equal mem[off] in the RESP cycle and 32'h0 in every other cycle, with all 32 bits returned regardless of sel.
REQ-030 The read data SHALL reflect every write acked before this request's RESP cycle.
REQ-031 Abort: bus__cyc low in any WAIT cycle SHALL send the FSM to IDLE with no ack, no err and no write.
REQ-032 stb dropping while cyc stays high in WAIT SHALL NOT abort; the captured transfer completes.
REQ-033 Inputs changing after capture SHALL have no effect on the in-flight transfer.
REQ-034 The wait counter SHALL be 2 bits wide and SHALL NOT wrap, since its load value is at most 2.
REQ-035 Simultaneous events: a cyc drop in the RESP cycle SHALL still end that transfer.
REQ-036 In the case of REQ-035 the write SHALL still commit, since the master sampled ack.

Reset
REQ-037 rst_n low SHALL immediately, with no clock, force state=IDLE, counter=0, bus__ack=0, bus__err=0 and bus__dat_r=0.
REQ-038 Memory contents SHALL NOT be reset, and the bench SHALL treat memory as X until written.
REQ-039 Reset asserted mid-transfer, in WAIT or RESP, SHALL discard that transfer with no write.
REQ-040 After rst_n rises, the first request SHALL be captured no earlier than the first rising edge with rst_n high.

Verification
REQ-041 WAIT_STATES=1: write adr=0x5, sel=4'hF, dat_w=0xDEADBEEF, held from cycle 0 -> ack high in cycle 1 only; then read adr=0x5 -> dat_r=0xDEADBEEF with ack in cycle 3.
REQ-042 Write 0x11223344 to adr 0x2, then write sel=4'b0100 dat_w=0xAABBCCDD to adr 0x2 -> readback of adr 0x2 = 0x11BB3344.
REQ-043 WAIT_STATES=3: read request at cycle 0 with cyc dropped in cycle 2 -> no ack in cycles 0-5; a new read at cycle 4 -> ack in cycle 7.
REQ-044 DEPTH_WORDS=256, BASE_ADR=0x100: read adr=0x0FF and adr=0x200 -> err=1, ack=0, dat_r=0 for both; write to adr=0x200 -> err=1 and memory is unchanged.
REQ-045 Assert rst_n low in a WAIT cycle of a write to adr 0x7 preloaded with 0x0 -> ack/err fall at once; after release, readback of adr 0x7 = 0x0.
REQ-046 Formal/random: cyc/stb held continuously for 64 cycles -> every ack is preceded by at least WAIT_STATES non-ack cycles, the ack count equals the capture count, and no cycle has both ack and err high.
